// File: rtl/dm_resp.sv
// Data-memory responder for the MEM stage: one outstanding load/store, fixed LATENCY response.
// Define DM_BUSERR_EN to add rsp_err and suppress stores to addresses beyond the storage.
module dm_resp #(
   parameter int DM_DEPTH = 10,
   parameter int LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
`ifdef DM_BUSERR_EN
   output logic        rsp_err,
`endif
   output logic        stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
   localparam int unsigned WORDS = 2 ** DM_DEPTH;

   logic [1:0]          state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [DM_DEPTH-1:0] idx_q, idx_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic [31:0] mem [WORDS];

   logic                req_err;
   logic                accept;
   logic                enter_resp;
   logic                op_wr;
   logic [DM_DEPTH-1:0] op_idx;
   logic [3:0]          op_be;
   logic [31:0]         op_wdata;
   logic                op_err;
   logic                addr_unused;

`ifdef DM_BUSERR_EN
   assign req_err = |req_addr[31:DM_DEPTH+2];
`else
   assign req_err = 1'b0;
`endif
   assign addr_unused = ^{req_addr[31:DM_DEPTH+2], req_addr[1:0]};

   assign accept = (state_q == S_IDLE) && req_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               idx_d   = req_addr[DM_DEPTH+1:2];
               be_d    = req_be;
               wdata_d = req_wdata;
               err_d   = req_err;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // RESP always returns to IDLE, so a next state of RESP marks the committing edge.
   assign enter_resp = (state_d == S_RESP);

   // With LATENCY==1 the commit happens on the accept edge, before the latches hold the request.
   assign op_wr    = (state_q == S_IDLE) ? req_wr                 : wr_q;
   assign op_idx   = (state_q == S_IDLE) ? req_addr[DM_DEPTH+1:2] : idx_q;
   assign op_be    = (state_q == S_IDLE) ? req_be                 : be_q;
   assign op_wdata = (state_q == S_IDLE) ? req_wdata              : wdata_q;
   assign op_err   = (state_q == S_IDLE) ? req_err                : err_q;

   always_comb begin
      rdata_d   = rdata_q;
      rsp_err_d = rsp_err_q;
      if (enter_resp) begin
         rdata_d   = (op_wr || op_err) ? 32'd0 : mem[op_idx];
         rsp_err_d = op_err;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         wr_q      <= 1'b0;
         idx_q     <= '0;
         be_q      <= 4'd0;
         wdata_q   <= 32'd0;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         idx_q     <= idx_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // NOTE: storage has no reset so it maps onto RAM; rst only blocks a commit on that edge.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && op_wr && !op_err) begin
         for (int i = 0; i < 4; i++) begin
            if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign stall     = accept || (state_q == S_WAIT);
`ifdef DM_BUSERR_EN
   assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
Data-memory responder for the 5-stage pipeline's MEM stage. It accepts one load/store request at a time from the memory-stage initiator and holds word storage with per-byte write enables. It returns read data after a fixed, parameterised latency. While a request is outstanding it drives a stall so the control unit can hold the pipe registers (pipeRegWr_*). Byte lane selection and sign/zero extension of load data stay downstream; this block always returns the full word.

Parameters:
DM_DEPTH, 10, word-address bits; storage is 2**DM_DEPTH x 32
LATENCY, 2, cycles from request acceptance to response; legal range 1..7

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present from MEM stage
req_ready  output  1  responder can accept a request this cycle
req_wr  input  1  1 = store, 0 = load
req_addr  input  32  byte address; word index = req_addr[DM_DEPTH+1:2]
req_be  input  4  byte enables for stores; bit i selects wdata[8i+7:8i]
req_wdata  input  32  store data, already lane-aligned
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  load data; 0 for stores
stall  output  1  hold the pipeline; request not yet answered

Behaviour:
- Reset (rst=1 at a clk edge): state←IDLE, cnt←0, rsp_valid←0, rsp_rdata←0, latched request cleared. Storage contents are not cleared.
- States:
  - IDLE: req_ready=1. On req_valid, latch wr/addr/be/wdata (the accept cycle is T). If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt←LATENCY-2.
  - WAIT: req_ready=0. If cnt==0, go to RESP; else cnt←cnt-1.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle, then IDLE. req_valid in RESP is ignored; the initiator advances on rsp_valid.
- Latency: rsp_valid is high in cycle T+LATENCY. Maximum throughput is one request per LATENCY+1 cycles.
- Memory effects, all at the edge entering RESP:
  - Load: rsp_rdata←mem[word index], registered and held until the next response or reset.
  - Store: mem lanes with be=1 are updated; rsp_rdata←0.
  - Store with be=4'b0000: no memory change; still responds normally.
- Addressing: req_addr[1:0] is ignored (misalignment is handled upstream). Bits above DM_DEPTH+1 are ignored, so addresses alias unless the optional feature below is compiled in.
- stall = (state==IDLE & req_valid) | (state==WAIT). It is combinational and is 0 in RESP and in idle-with-no-request.
- Reset during WAIT or RESP: the request is abandoned, no response is issued, and a pending store that has not yet entered RESP is not committed.
- Inputs are sampled only in the accept cycle; changes to req_* during WAIT have no effect.

Optional Feature:
DM_BUSERR_EN
- Defined:
  - Adds output rsp_err (1 bit, reset 0), valid with rsp_valid.
  - rsp_err=1 when latched req_addr[31:DM_DEPTH+2] != 0.
  - On error: store is suppressed, rsp_rdata=0; timing is unchanged.
- Undefined: no rsp_err port; upper address bits are ignored (aliasing).

Test Plan:
1. Reset: rst=1 for 2 cycles, then 0, req_valid=0 -> rsp_valid=0, rsp_rdata=0, req_ready=1, stall=0.
2. Store then load, LATENCY=2:
   - store 0x12345678 to 0x10, be=4'b1111, accepted at T -> stall=1 at T and T+1, rsp_valid=1 at T+2 with rsp_rdata=0.
   - load 0x10 -> rsp_rdata=0x12345678 two cycles after accept.
3. Partial store: store 0xAABBCCDD to 0x10, be=4'b0100 -> subsequent load of 0x10 returns 0x12BB5678. Store with be=4'b0000 -> load still returns 0x12BB5678.
4. Reset mid-operation: store 0xFFFFFFFF to 0x10, assert rst in the WAIT cycle -> no rsp_valid; after reset, load 0x10 returns 0x12BB5678.
5. Back-to-back: req_valid held high for three loads, first accepted at T -> rsp_valid only at T+2, T+5, T+8; req_ready low in WAIT and RESP.
6. LATENCY=1 build:
   - load accepted at T -> rsp_valid at T+1, stall=1 only at T.
   - With DM_BUSERR_EN: store to 0x80000010 -> rsp_err=1, and load 0x10 is unchanged.
